// File: rtl/sound_request_arbiter.sv
`default_nettype none
// ============================================================================
// sound_request_arbiter - latches loser/explosion/endgame sound requests and
//                         starts one controller sequence at a time by priority
// Revision: 1.0
// ============================================================================
module sound_request_arbiter #(
    parameter int LOSER_LEN   = 2,
    parameter int EXPL_LEN    = 4,
    parameter int ENDGAME_LEN = 7,
    parameter int GAP_CYCLES  = 2,
    parameter int EXPL_QMAX   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       OneSecPulse,
    input  logic       req_loser,
    input  logic       req_explosion,
    input  logic       req_endgame,
    input  logic       mute,
    output logic       enable_LOSER_1,
    output logic       enable_EXPLOSION_SOUND_START,
    output logic       enable_ENDGAME_INTRO_1,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [1:0] expl_pending
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] c_ID_NONE    = 2'd0;
    localparam logic [1:0] c_ID_LOSER   = 2'd1;
    localparam logic [1:0] c_ID_EXPL    = 2'd2;
    localparam logic [1:0] c_ID_END     = 2'd3;
    localparam logic [2:0] c_LOSER_LEN  = 3'(LOSER_LEN);
    localparam logic [2:0] c_EXPL_LEN   = 3'(EXPL_LEN);
    localparam logic [2:0] c_END_LEN    = 3'(ENDGAME_LEN);
    localparam logic [1:0] c_GAP_LAST   = 2'(GAP_CYCLES - 1);
    localparam logic [1:0] c_QMAX       = 2'(EXPL_QMAX);

    state_t     r_state;
    logic       r_pend_loser;
    logic       r_pend_end;
    logic [1:0] r_expl_cnt;
    logic [1:0] r_active_id;
    logic [2:0] r_tick_cnt;
    logic [1:0] r_gap_cnt;

    state_t     w_state_nxt;
    logic       w_pend_loser_nxt;
    logic       w_pend_end_nxt;
    logic [1:0] w_expl_nxt;
    logic [1:0] w_id_nxt;
    logic [2:0] w_tick_nxt;
    logic [1:0] w_gap_nxt;
    logic       w_expl_take;
    logic       w_expl_clear;
    logic [2:0] w_len;
    logic [2:0] w_tick_inc;

    always_comb begin
        w_len = c_LOSER_LEN;
        case (r_active_id)
            c_ID_EXPL: w_len = c_EXPL_LEN;
            c_ID_END:  w_len = c_END_LEN;
            default:   w_len = c_LOSER_LEN;
        endcase
    end

    assign w_tick_inc = r_tick_cnt + 3'd1;

    // Incoming requests are folded into the pending view so a request arriving
    // while IDLE is granted in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_loser_nxt = r_pend_loser | req_loser;
        w_pend_end_nxt   = r_pend_end | req_endgame;
        w_id_nxt         = r_active_id;
        w_tick_nxt       = r_tick_cnt;
        w_gap_nxt        = r_gap_cnt;
        w_expl_take      = 1'b0;
        w_expl_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pend_end_nxt || w_pend_loser_nxt || (r_expl_cnt != 2'd0) || req_explosion) begin
                    if (w_pend_end_nxt) begin
                        w_id_nxt         = c_ID_END;
                        w_pend_end_nxt   = 1'b0;
                        w_pend_loser_nxt = 1'b0;
                        w_expl_clear     = 1'b1;
                    end else if (w_pend_loser_nxt) begin
                        w_id_nxt         = c_ID_LOSER;
                        w_pend_loser_nxt = 1'b0;
                    end else begin
                        w_id_nxt         = c_ID_EXPL;
                        w_expl_take      = 1'b1;
                    end
                    w_gap_nxt   = 2'd0;
                    w_tick_nxt  = 3'd0;
                    w_state_nxt = mute ? ST_GAP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_tick_nxt  = 3'd0;
                w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (OneSecPulse) begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick_inc == w_len) begin
                        w_gap_nxt   = 2'd0;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_id_nxt    = c_ID_NONE;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A request and a consume in the same cycle cancel out.
    always_comb begin
        w_expl_nxt = r_expl_cnt;
        if (w_expl_clear) begin
            w_expl_nxt = 2'd0;
        end else if (w_expl_take && !req_explosion) begin
            w_expl_nxt = r_expl_cnt - 2'd1;
        end else if (!w_expl_take && req_explosion && (r_expl_cnt != c_QMAX)) begin
            w_expl_nxt = r_expl_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pend_loser <= 1'b0;
            r_pend_end   <= 1'b0;
            r_expl_cnt   <= 2'd0;
            r_active_id  <= c_ID_NONE;
            r_tick_cnt   <= 3'd0;
            r_gap_cnt    <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_loser <= w_pend_loser_nxt;
            r_pend_end   <= w_pend_end_nxt;
            r_expl_cnt   <= w_expl_nxt;
            r_active_id  <= w_id_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_gap_cnt    <= w_gap_nxt;
        end
    end

    assign enable_LOSER_1               = (r_state == ST_ISSUE) && (r_active_id == c_ID_LOSER);
    assign enable_EXPLOSION_SOUND_START = (r_state == ST_ISSUE) && (r_active_id == c_ID_EXPL);
    assign enable_ENDGAME_INTRO_1       = (r_state == ST_ISSUE) && (r_active_id == c_ID_END);
    assign busy                         = (r_state != ST_IDLE);
    assign active_id                    = r_active_id;
    assign expl_pending                 = r_expl_cnt;

    a_enable_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({enable_LOSER_1, enable_EXPLOSION_SOUND_START, enable_ENDGAME_INTRO_1}));

    a_enable_single_cycle: assert property (@(posedge clk) disable iff (reset)
        (enable_LOSER_1 || enable_EXPLOSION_SOUND_START || enable_ENDGAME_INTRO_1) |=>
        !(enable_LOSER_1 || enable_EXPLOSION_SOUND_START || enable_ENDGAME_INTRO_1));

endmodule
`default_nettype wire

// File: tb/tb_sound_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sound_request_arbiter - directed stimulus with a cycle-level reference
//                            model and hand-computed literal expectations
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sound_request_arbiter;

    localparam int LOSER_LEN   = 2;
    localparam int EXPL_LEN    = 4;
    localparam int ENDGAME_LEN = 7;
    localparam int GAP_CYCLES  = 2;
    localparam int EXPL_QMAX   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       OneSecPulse = 1'b0;
    logic       req_loser = 1'b0;
    logic       req_explosion = 1'b0;
    logic       req_endgame = 1'b0;
    logic       mute = 1'b0;
    logic       en_l;
    logic       en_x;
    logic       en_e;
    logic       busy;
    logic [1:0] active_id;
    logic [1:0] expl_pending;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  tick_en = 1'b0;
    int  tot_l = 0;
    int  tot_x = 0;
    int  tot_e = 0;

    always #5 clk = ~clk;

    sound_request_arbiter #(
        .LOSER_LEN(LOSER_LEN), .EXPL_LEN(EXPL_LEN), .ENDGAME_LEN(ENDGAME_LEN),
        .GAP_CYCLES(GAP_CYCLES), .EXPL_QMAX(EXPL_QMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .OneSecPulse(OneSecPulse),
        .req_loser(req_loser),
        .req_explosion(req_explosion),
        .req_endgame(req_endgame),
        .mute(mute),
        .enable_LOSER_1(en_l),
        .enable_EXPLOSION_SOUND_START(en_x),
        .enable_ENDGAME_INTRO_1(en_e),
        .busy(busy),
        .active_id(active_id),
        .expl_pending(expl_pending)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: sequence occupancy is a countdown of remaining ticks
    // and remaining guard cycles; the controller is free when both are spent.
    bit m_pl, m_pe, m_issue;
    int m_cnt, m_ticks, m_gap, m_id;

    function automatic int seq_len(input int id);
        if (id == 3) return ENDGAME_LEN;
        if (id == 2) return EXPL_LEN;
        return LOSER_LEN;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit pl, pe, iss;
        int cnt, tk, gp, id;
        if (reset) begin
            m_pl <= 0; m_pe <= 0; m_issue <= 0;
            m_cnt <= 0; m_ticks <= 0; m_gap <= 0; m_id <= 0;
        end else begin
            pl = m_pl | req_loser;
            pe = m_pe | req_endgame;
            cnt = m_cnt + int'(req_explosion);
            iss = m_issue; tk = m_ticks; gp = m_gap; id = m_id;
            if (m_issue) begin
                iss = 0;
                tk = seq_len(m_id);
            end else if (m_ticks > 0) begin
                if (OneSecPulse) tk = m_ticks - 1;
                if (tk == 0) gp = GAP_CYCLES;
            end else if (m_gap > 0) begin
                gp = m_gap - 1;
                if (gp == 0) id = 0;
            end else if (pe || pl || cnt > 0) begin
                if (pe) begin
                    id = 3; pe = 0; pl = 0; cnt = 0;
                end else if (pl) begin
                    id = 1; pl = 0;
                end else begin
                    id = 2; cnt = cnt - 1;
                end
                if (mute) gp = GAP_CYCLES;
                else iss = 1;
            end
            if (cnt > EXPL_QMAX) cnt = EXPL_QMAX;
            m_pl <= pl; m_pe <= pe; m_issue <= iss;
            m_cnt <= cnt; m_ticks <= tk; m_gap <= gp; m_id <= id;
        end
    end

    always @(negedge clk) begin
        check("en_loser",    int'(en_l), int'(m_issue && m_id == 1));
        check("en_expl",     int'(en_x), int'(m_issue && m_id == 2));
        check("en_endgame",  int'(en_e), int'(m_issue && m_id == 3));
        check("busy",        int'(busy), int'(m_issue || m_ticks > 0 || m_gap > 0));
        check("active_id",   int'(active_id), m_id);
        check("expl_pending", int'(expl_pending), m_cnt);
    end

    always @(negedge clk) begin
        tot_l <= tot_l + int'(en_l);
        tot_x <= tot_x + int'(en_x);
        tot_e <= tot_e + int'(en_e);
    end

    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                ph = (ph + 1) % 10;
                OneSecPulse = (ph == 0);
            end else begin
                ph = 0;
                OneSecPulse = 1'b0;
            end
        end
    end

    task automatic wait_quiet(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || expl_pending != 2'd0) && n < max_cyc);
        check({name, "_quiet"}, int'(busy || expl_pending != 2'd0), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_en"}, int'({en_l, en_x, en_e}), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_id"}, int'(active_id), 0);
        check({name, "_pend"}, int'(expl_pending), 0);
    endtask

    initial begin : main
        int sl, sx, se, nb;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tick_en = 1'b1;
        repeat (3) @(negedge clk);

        // single loser request
        sl = tot_l; sx = tot_x; se = tot_e;
        req_loser = 1'b1;
        @(negedge clk);
        req_loser = 1'b0;
        check("loser_pulse", int'(en_l), 1);
        check("loser_id", int'(active_id), 1);
        @(negedge clk);
        check("loser_pulse_end", int'(en_l), 0);
        check("loser_id_hold", int'(active_id), 1);
        wait_quiet("loser", 400);
        check("loser_count", tot_l - sl, 1);
        check("loser_other", (tot_x - sx) + (tot_e - se), 0);

        // three explosions back to back
        sx = tot_x;
        req_explosion = 1'b1;
        @(negedge clk);
        check("expl3_first_pulse", int'(en_x), 1);
        check("expl3_pend0", int'(expl_pending), 0);
        @(negedge clk);
        @(negedge clk);
        req_explosion = 1'b0;
        check("expl3_pend2", int'(expl_pending), 2);
        wait_quiet("expl3", 1500);
        check("expl3_count", tot_x - sx, 3);

        // five explosions while the loser sequence is playing
        sl = tot_l; sx = tot_x;
        req_loser = 1'b1;
        @(negedge clk);
        req_loser = 1'b0;
        req_explosion = 1'b1;
        repeat (5) @(negedge clk);
        req_explosion = 1'b0;
        check("sat_pend", int'(expl_pending), EXPL_QMAX);
        check("sat_busy", int'(busy), 1);
        wait_quiet("sat", 2000);
        check("sat_loser_count", tot_l - sl, 1);
        check("sat_expl_count", tot_x - sx, 3);

        // all three requests in the same cycle
        sl = tot_l; sx = tot_x; se = tot_e;
        req_loser = 1'b1; req_explosion = 1'b1; req_endgame = 1'b1;
        @(negedge clk);
        req_loser = 1'b0; req_explosion = 1'b0; req_endgame = 1'b0;
        check("all_id", int'(active_id), 3);
        check("all_pulse", int'(en_e), 1);
        check("all_pend", int'(expl_pending), 0);
        wait_quiet("all", 1500);
        repeat (30) @(negedge clk);
        check("all_end_count", tot_e - se, 1);
        check("all_no_more", (tot_l - sl) + (tot_x - sx), 0);
        check("all_idle", int'(busy), 0);

        // muted loser request
        sl = tot_l; sx = tot_x; se = tot_e;
        mute = 1'b1;
        req_loser = 1'b1;
        @(negedge clk);
        req_loser = 1'b0;
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        mute = 1'b0;
        check("mute_busy_cycles", nb, GAP_CYCLES);
        repeat (20) @(negedge clk);
        check("mute_no_pulse", (tot_l - sl) + (tot_x - sx) + (tot_e - se), 0);
        check("mute_idle", int'(busy), 0);

        // reset in the middle of an endgame sequence
        sl = tot_l; se = tot_e;
        req_endgame = 1'b1;
        @(negedge clk);
        req_endgame = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_id", int'(active_id), 3);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req_loser = 1'b1;
        @(negedge clk);
        req_loser = 1'b0;
        check("post_reset_pulse", int'(en_l), 1);
        check("post_reset_id", int'(active_id), 1);
        wait_quiet("post_reset", 400);
        check("post_reset_loser_count", tot_l - sl, 1);
        check("post_reset_end_count", tot_e - se, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sound_request_arbiter.md
Name: sound_request_arbiter

Overview:
- Sits between the game-logic event sources and Sound_Controller.
- Latches one-cycle sound requests (loser, explosion, endgame) and grants one at a time by priority.
- Issues a one-cycle start pulse on the matching controller enable, then holds off until that sequence has finished, tracked by counting OneSecPulse ticks.
- Queues repeated explosion requests so that overlapping bombs each produce a sound.

Parameters:
- LOSER_LEN, 2, OneSecPulse ticks the loser sequence occupies the controller.
- EXPL_LEN, 4, OneSecPulse ticks the explosion sequence occupies the controller.
- ENDGAME_LEN, 7, OneSecPulse ticks the endgame sequence occupies the controller.
- GAP_CYCLES, 2, clk cycles of idle guard after a sequence, so the controller reaches IDLE_ST.
- EXPL_QMAX, 3, saturation value of the explosion pending counter.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- OneSecPulse  in  1  timing tick shared with Sound_Controller
- req_loser  in  1  one-cycle request
- req_explosion  in  1  one-cycle request
- req_endgame  in  1  one-cycle request
- mute  in  1  discard grants instead of playing them
- enable_LOSER_1  out  1  one-cycle start pulse to controller
- enable_EXPLOSION_SOUND_START  out  1  one-cycle start pulse to controller
- enable_ENDGAME_INTRO_1  out  1  one-cycle start pulse to controller
- busy  out  1  high in ISSUE, PLAY, GAP
- active_id  out  2  0 none, 1 loser, 2 explosion, 3 endgame
- expl_pending  out  2  explosion queue count

Behaviour:
- Reset values: state IDLE; all enables 0; busy 0; active_id 0; expl_pending 0; pending bits 0; counters 0.
- Pending capture:
  - req_loser sets pend_loser.
  - req_endgame sets pend_end.
  - req_explosion increments expl_pending, saturating at EXPL_QMAX; extra requests are dropped.
  - Capture happens in every state.
- Priority: endgame > loser > explosion.
- State IDLE:
  - If any request is pending, select the highest-priority source and consume it: clear its bit or decrement the counter.
  - Latch active_id.
  - If mute=0, go to ISSUE; if mute=1, go to GAP (sound discarded, no enable pulse).
- Endgame grant: clears pend_loser and expl_pending in the same cycle, including any request captured in that cycle.
- Simultaneous request and consume of explosion in one cycle: net count unchanged.
- State ISSUE (exactly 1 cycle):
  - The enable matching active_id is 1; all others stay 0.
  - OneSecPulse is ignored in this cycle.
  - Next state PLAY; tick counter cleared.
- State PLAY:
  - Count OneSecPulse ticks.
  - On the tick that makes count equal the length for active_id (LOSER_LEN / EXPL_LEN / ENDGAME_LEN), go to GAP.
- State GAP:
  - Count GAP_CYCLES clk cycles, then go to IDLE with active_id=0.
- Enables:
  - Driven only from ISSUE, decoded from registered state and active_id.
  - Never high for two consecutive cycles.
  - Never more than one high at a time.
- Non-preemptive: a pending endgame waits for the current PLAY/GAP to finish.
- Reset mid-sequence: everything returns to reset values immediately; no enable glitch. The controller is reset by the same event.
- Counter widths: tick counter 3 bits (max length 7), gap counter 2 bits.

Test Plan:
- Single req_loser, pulses every 10 clk:
  - enable_LOSER_1 high exactly 1 cycle, one cycle after the request.
  - busy falls 2 ticks + GAP_CYCLES later.
  - active_id=1 throughout.
- Three req_explosion 1 cycle apart:
  - expl_pending reaches 2 after the first grant.
  - Three enable_EXPLOSION_SOUND_START pulses, each separated by 4 ticks + 2 cycles + 1.
- Five req_explosion while busy with loser:
  - expl_pending saturates at 3.
  - Exactly 3 explosion pulses afterwards.
- req_loser, req_explosion and req_endgame in the same cycle from IDLE:
  - Endgame granted (active_id=3).
  - pend_loser and expl_pending cleared.
  - No further grants after the sequence.
- mute=1 with req_loser:
  - No enable pulse.
  - busy high for GAP_CYCLES only.
  - Pending cleared.
- reset asserted during PLAY of endgame:
  - All outputs 0 asynchronously.
  - A new req_loser after release produces the normal pulse.
